keydata_load_ctrl: RTL

//  Keypad entry sequencer for the function generator's 16-bit key-data registers.
//  - Collects up to 4 BCD digits from the keypad decoder into a nibble-packed entry value.
//  - On Enter, issues a one-cycle load enable to the selected target register
//    (frequency, amplitude, offset, ...). Each target is a 16-bit register with load enable.
//  - Sits between the keypad decoder and the bank of key-data registers.

---
 rtl/keydata_load_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/keydata_load_ctrl.sv
// Keypad entry sequencer: packs up to four BCD digits and commits them to one of NUM_TARGETS key-data registers.
// Optional partial-entry idle timeout is compiled in with `define KEY_TIMEOUT_EN.
module keydata_load_ctrl #(
  parameter int unsigned NUM_TARGETS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_key_valid,
  input  logic [3:0]             i_key_code,
  output logic [NUM_TARGETS-1:0] o_load_en,
  output logic [15:0]            o_load_data,
  output logic [15:0]            o_entry,
  output logic [2:0]             o_digit_cnt,
  output logic [1:0]             o_sel,
  output logic                   o_err
);

  localparam logic [3:0]  KEY_ENTER  = 4'hA;
  localparam logic [3:0]  KEY_CLEAR  = 4'hB;
  localparam logic [3:0]  KEY_SELECT = 4'hC;
  localparam logic [3:0]  KEY_BKSP   = 4'hD;
  localparam int unsigned MAX_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t r_state;

  logic w_is_digit;
  logic w_full;
  logic w_last_sel;
  logic w_to_hit;

  assign w_is_digit = (i_key_code <= 4'd9);
  assign w_full     = (o_digit_cnt == 3'(MAX_DIGITS));
  assign w_last_sel = (o_sel == 2'(NUM_TARGETS - 1));

`ifdef KEY_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt;

  // A pending key always beats the timeout in the same cycle
  assign w_to_hit = (r_state == ST_ENTRY) && !i_key_valid &&
                    (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state != ST_ENTRY) || i_key_valid || w_to_hit) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  assign w_to_hit = 1'b0;

  // Marker block only; the timeout period has no effect in this build
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_unused
  end
`endif

  // Key decode, entry packing and commit sequencing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      o_load_en   <= '0;
      o_load_data <= '0;
      o_entry     <= '0;
      o_digit_cnt <= '0;
      o_sel       <= '0;
      o_err       <= 1'b0;
    end else begin
      o_load_en <= '0;
      o_err     <= 1'b0;

      if (r_state == ST_COMMIT) begin
        r_state <= ST_IDLE;
        if (i_key_valid) begin
          o_err <= 1'b1;
        end
      end else if (i_key_valid) begin
        if (w_is_digit) begin
          if (w_full) begin
            o_err <= 1'b1;
          end else begin
            o_entry     <= {o_entry[11:0], i_key_code};
            o_digit_cnt <= o_digit_cnt + 3'd1;
            r_state     <= ST_ENTRY;
          end
        end else begin
          case (i_key_code)
            KEY_ENTER: begin
              if (r_state == ST_ENTRY) begin
                o_load_en   <= NUM_TARGETS'(1) << o_sel;
                o_load_data <= o_entry;
                o_entry     <= '0;
                o_digit_cnt <= '0;
                r_state     <= ST_COMMIT;
              end else begin
                o_err <= 1'b1;
              end
            end
            KEY_CLEAR: begin
              o_entry     <= '0;
              o_digit_cnt <= '0;
              r_state     <= ST_IDLE;
            end
            KEY_SELECT: begin
              if (r_state == ST_IDLE) begin
                o_sel <= w_last_sel ? 2'd0 : o_sel + 2'd1;
              end else begin
                o_err <= 1'b1;
              end
            end
            KEY_BKSP: begin
              if (r_state == ST_ENTRY) begin
                o_entry     <= {4'h0, o_entry[15:4]};
                o_digit_cnt <= o_digit_cnt - 3'd1;
                if (o_digit_cnt == 3'd1) begin
                  r_state <= ST_IDLE;
                end
              end
            end
            default: begin
              o_err <= 1'b1;
            end
          endcase
        end
      end else if (w_to_hit) begin
        o_entry     <= '0;
        o_digit_cnt <= '0;
        o_err       <= 1'b1;
        r_state     <= ST_IDLE;
      end
    end
  end

endmodule
